psum_axis_serializer: RTL

//  Downstream stage of the accelerator top: captures one 1280-bit partial-sum vector (psum_out)
//  per psum_valid/psum_ready handshake and drains it as 32-bit AXI4-Stream master beats toward the DMA.

---
 rtl/psum_axis_serializer_pkg.sv | 12 +
 rtl/psum_axis_serializer.sv | 100 ++++++++++
 2 files changed

// File: rtl/psum_axis_serializer_pkg.sv
// Shared constants and state type for the partial-sum AXI4-Stream serializer.
package psum_axis_serializer_pkg;

    localparam int DEF_PSUM_WIDTH = 1280;
    localparam int DEF_AXIS_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/psum_axis_serializer.sv
// Captures one wide partial-sum vector per valid/ready handshake and drains it
// LSB-first as AXI4-Stream beats, reporting the number of completed vectors.
module psum_axis_serializer
    import psum_axis_serializer_pkg::*;
#(
    parameter int PSUM_WIDTH           = DEF_PSUM_WIDTH,
    parameter int C_M_AXIS_TDATA_WIDTH = DEF_AXIS_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PSUM_WIDTH-1:0]             psum_in,
    input  logic                              psum_valid,
    input  logic                              psum_last,
    output logic                              psum_ready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY,
    input  logic                              count_clear,
    output logic [31:0]                       vec_count,
    output logic                              busy
);

    localparam int BEATS = PSUM_WIDTH / C_M_AXIS_TDATA_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        beat_cnt_q;
    logic [PSUM_WIDTH-1:0]   vec_q;
    logic                    last_q;
    logic [31:0]             vec_count_q;

    logic beat_fire;
    logic final_fire;
    logic capture;

    assign beat_fire  = (state_q == SEND) && M_AXIS_TREADY;
    assign final_fire = beat_fire && (beat_cnt_q == LAST_BEAT);
    assign psum_ready = (state_q == IDLE) || final_fire;
    assign capture    = psum_valid && psum_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (psum_valid) state_d = SEND;
            SEND:    if (final_fire && !psum_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the held vector is a plain register, not a RAM, so it is cleared
    // by reset; this guarantees TDATA reads zero and no stale tail survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q      <= '0;
            last_q     <= 1'b0;
            beat_cnt_q <= '0;
        end else if (capture) begin
            vec_q      <= psum_in;
            last_q     <= psum_last;
            beat_cnt_q <= '0;
        end else if (beat_fire) begin
            // Shifting keeps the current beat in the low word, avoiding a wide mux.
            vec_q      <= vec_q >> C_M_AXIS_TDATA_WIDTH;
            beat_cnt_q <= (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count_q <= '0;
        end else if (count_clear) begin
            vec_count_q <= '0;
        end else if (final_fire) begin
            vec_count_q <= vec_count_q + 32'd1;
        end
    end

    assign M_AXIS_TDATA  = vec_q[C_M_AXIS_TDATA_WIDTH-1:0];
    assign M_AXIS_TSTRB  = '1;
    assign M_AXIS_TVALID = (state_q == SEND);
    assign M_AXIS_TLAST  = (state_q == SEND) && last_q && (beat_cnt_q == LAST_BEAT);
    assign vec_count     = vec_count_q;
    assign busy          = (state_q == SEND);

endmodule
